// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned shift-add multiply / restoring divide datapath, one bit per step.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [2*XLEN-1:0] load_val,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_top;
  logic [XLEN:0]     div_diff;
  logic              div_ge;

  // Multiply: {product_hi, multiplier} shifts right; divide: {rem, quo} shifts left.
  always_comb begin
    acc_d    = acc_q;
    b_d      = b_q;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_top  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_top - {1'b0, b_q};
    div_ge   = (div_top >= {1'b0, b_q});
    if (load) begin
      acc_d = load_val;
      b_d   = divisor;
    end else if (step) begin
      if (is_div) begin
        acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_top[XLEN-1:0]),
                 acc_q[XLEN-2:0], div_ge};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M MUL/DIV/REM sequencer: stalls EX, iterates XLEN cycles, returns a registered result.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            Stall,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  op_e               op_in;
  logic              sign_a, sign_b, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem, sel;
  logic [2*XLEN-1:0] prod, load_val, acc;
  logic              core_load, core_step;

  // Operand decode for the request presented in IDLE.
  always_comb begin
    op_in    = op_e'(Funct3);
    sign_a   = SrcA[XLEN-1] && !(op_in inside {OP_MULHU, OP_DIVU, OP_REMU});
    sign_b   = SrcB[XLEN-1] && (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    mag_a    = sign_a ? -SrcA : SrcA;
    mag_b    = sign_b ? -SrcB : SrcB;
    div_zero = Funct3[2] && (SrcB == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
               (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
  end

  // Sign fix and output select from the magnitude result.
  always_comb begin
    prod = neg_quo_q ? -acc : acc;
    quo  = neg_quo_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        sel = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  sel = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               sel = quo;
      default:                       sel = rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    load_val  = {XLEN'(0), mag_a};
    case (state_q)
      ST_IDLE: begin
        if (Start && !Flush) begin
          op_d      = op_in;
          cnt_d     = '0;
          core_load = 1'b1;
          // Special cases preload {rem, quo} unsigned and skip iteration.
          if (div_zero) begin
            load_val  = {SrcA, {XLEN{1'b1}}};
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = ST_FIX;
          end else if (div_ovf) begin
            load_val  = {XLEN'(0), SrcA};
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = ST_FIX;
          end else begin
            neg_quo_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FIX: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = sel;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  muldiv_core u_core (
    .clk      (clk),
    .rst_n    (reset),
    .load     (core_load),
    .step     (core_step),
    .is_div   (op_q[2]),
    .load_val (load_val),
    .divisor  (mag_b),
    .acc      (acc)
  );

  // Combinational so the requesting instruction is held in its own Start cycle.
  assign Stall  = reset && ((state_q == ST_CALC) || (state_q == ST_FIX) ||
                            ((state_q == ST_IDLE) && Start));
  assign Done   = done_q;
  assign Result = result_q;

endmodule
